// File: rtl/f_fetch_stage_pkg.sv
// Shared constants, F/D register op encoding and the fetch-address check for the fetch stage.
package f_fetch_stage_pkg;

  localparam logic [31:0] PC_INIT_DEF   = 32'h0000_3000;
  localparam logic [31:0] PC_MIN_DEF    = 32'h0000_3000;
  localparam logic [31:0] PC_MAX_DEF    = 32'h0000_6ffc;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;

  localparam logic [4:0] EXCCODE_NONE = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;

  typedef enum logic [1:0] {
    FD_LOAD  = 2'd0,
    FD_HOLD  = 2'd1,
    FD_FLUSH = 2'd2
  } fd_op_e;

  // Misaligned or outside [lo, hi] (unsigned, inclusive) yields a single AdEL.
  function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/f_fd_reg.sv
// F/D pipeline register: load, hold, or flush to a nop tagged with a caller-supplied PC.
module f_fd_reg
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  fd_op_e      i_op,
  input  logic [31:0] i_flush_pc,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic [4:0]  i_exccode,
  input  logic        i_bd,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [4:0]  o_exccode,
  output logic        o_bd
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [4:0]  r_exccode;
  logic        r_bd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= PC_INIT;
      r_instr   <= 32'd0;
      r_exccode <= EXCCODE_NONE;
      r_bd      <= 1'b0;
    end else begin
      case (i_op)
        FD_FLUSH: begin
          r_pc      <= i_flush_pc;
          r_instr   <= 32'd0;
          r_exccode <= EXCCODE_NONE;
          r_bd      <= 1'b0;
        end
        FD_LOAD: begin
          r_pc      <= i_pc;
          r_instr   <= i_instr;
          r_exccode <= i_exccode;
          r_bd      <= i_bd;
        end
        default: begin
          r_pc      <= r_pc;
          r_instr   <= r_instr;
          r_exccode <= r_exccode;
          r_bd      <= r_bd;
        end
      endcase
    end
  end

  assign o_pc      = r_pc;
  assign o_instr   = r_instr;
  assign o_exccode = r_exccode;
  assign o_bd      = r_bd;

endmodule

// File: rtl/f_fetch_stage.sv
// Fetch stage: F_PC register, fetch-address check and F/D register control.
// Define FETCH_ADEL_EN to enable the AdEL fetch-address check.
module f_fetch_stage
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = PC_INIT_DEF,
  parameter logic [31:0] PC_MIN    = PC_MIN_DEF,
  parameter logic [31:0] PC_MAX    = PC_MAX_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Npc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic        D_is_branch,
  input  logic [31:0] F_Instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD
);

`ifdef FETCH_ADEL_EN
  localparam logic ADEL_EN = 1'b1;
`else
  localparam logic ADEL_EN = 1'b0;
`endif

  logic [31:0] r_pc;
  logic        w_bad;
  logic [31:0] w_instr;
  logic [4:0]  w_exccode;
  fd_op_e      w_op;
  logic [31:0] w_flush_pc;

  always_ff @(posedge clk) begin
    if (!reset)     r_pc <= PC_INIT;
    else if (req)   r_pc <= EXC_ENTRY;
    else if (stall) r_pc <= r_pc;
    else            r_pc <= Npc;
  end

  assign w_bad     = ADEL_EN & fetch_addr_bad(r_pc, PC_MIN, PC_MAX);
  assign w_instr   = w_bad ? 32'd0 : F_Instr;
  assign w_exccode = w_bad ? EXCCODE_ADEL : EXCCODE_NONE;

  // eret flushes the word fetched behind it; a stalled eret waits for the first free edge.
  always_comb begin
    w_op       = FD_LOAD;
    w_flush_pc = r_pc;
    if (req) begin
      w_op       = FD_FLUSH;
      w_flush_pc = EXC_ENTRY;
    end else if (stall) begin
      w_op = FD_HOLD;
    end else if (eret) begin
      w_op = FD_FLUSH;
    end
  end

  f_fd_reg #(
    .PC_INIT (PC_INIT)
  ) u_fd_reg (
    .clk        (clk),
    .reset      (reset),
    .i_op       (w_op),
    .i_flush_pc (w_flush_pc),
    .i_pc       (r_pc),
    .i_instr    (w_instr),
    .i_exccode  (w_exccode),
    .i_bd       (D_is_branch),
    .o_pc       (D_PC),
    .o_instr    (D_Instr),
    .o_exccode  (D_ExcCode),
    .o_bd       (D_BD)
  );

  assign F_PC = r_pc;

endmodule
